// File: rtl/fixed_to_float.sv
// Signed fixed-point (Q(WIDTH-FRAC).FRAC) to IEEE-754 single-precision converter.
// Normalises one bit per clock, then rounds to nearest-even in a single ROUND cycle.
module fixed_to_float #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned FRAC  = 30
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_in,
  input  logic [WIDTH-1:0] fixed_in,
  output logic [31:0]      float_out,
  output logic             done,
  output logic             busy
);

  localparam int unsigned CW       = $clog2(WIDTH) + 1;
  localparam int unsigned EXP_BIAS = 127 + WIDTH - 1 - FRAC;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] NORM  = 2'd1;
  localparam logic [1:0] ROUND = 2'd2;

  logic [1:0]       state, state_nxt;
  logic             sign, sign_nxt;
  logic             zero, zero_nxt;
  logic [WIDTH-1:0] mag, mag_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [31:0]      float_nxt;
  logic             done_nxt;
  logic             busy_nxt;

  logic [22:0]      man;
  logic             guard;
  logic             sticky;
  logic             round_up;
  logic [23:0]      man_sum;
  logic [7:0]       exp_base;
  logic [7:0]       exp_fin;

  // Rounding datapath on the normalised magnitude (leading one at mag[WIDTH-1])
  assign man      = mag[WIDTH-2:WIDTH-24];
  assign guard    = mag[WIDTH-25];

  generate
    if (WIDTH > 25) begin : g_sticky
      assign sticky = |mag[WIDTH-26:0];
    end else begin : g_no_sticky
      assign sticky = 1'b0;
    end
  endgenerate

  assign round_up = guard & (sticky | man[0]);
  assign man_sum  = {1'b0, man} + 24'(round_up);
  assign exp_base = 8'(EXP_BIAS) - 8'(cnt);
  // A carry out of the mantissa leaves it all-zero and bumps the exponent
  assign exp_fin  = exp_base + 8'(man_sum[23]);

  // Next-state and next-output logic
  always_comb begin
    state_nxt = state;
    sign_nxt  = sign;
    zero_nxt  = zero;
    mag_nxt   = mag;
    cnt_nxt   = cnt;
    float_nxt = float_out;
    done_nxt  = 1'b0;
    busy_nxt  = busy;
    case (state)
      IDLE: begin
        if (valid_in) begin
          sign_nxt  = fixed_in[WIDTH-1];
          mag_nxt   = fixed_in[WIDTH-1] ? (~fixed_in + WIDTH'(1)) : fixed_in;
          cnt_nxt   = '0;
          zero_nxt  = (fixed_in == '0);
          busy_nxt  = 1'b1;
          state_nxt = (fixed_in == '0) ? ROUND : NORM;
        end
      end
      NORM: begin
        if (mag[WIDTH-1]) begin
          state_nxt = ROUND;
        end else begin
          mag_nxt = mag << 1;
          cnt_nxt = cnt + CW'(1);
        end
      end
      ROUND: begin
        float_nxt = zero ? 32'h0000_0000 : {sign, exp_fin, man_sum[22:0]};
        done_nxt  = 1'b1;
        busy_nxt  = 1'b0;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      sign      <= 1'b0;
      zero      <= 1'b0;
      mag       <= '0;
      cnt       <= '0;
      float_out <= '0;
      done      <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      sign      <= sign_nxt;
      zero      <= zero_nxt;
      mag       <= mag_nxt;
      cnt       <= cnt_nxt;
      float_out <= float_nxt;
      done      <= done_nxt;
      busy      <= busy_nxt;
    end
  end

endmodule
